multicycle_alu_ctrl: RTL

//  Parametrised ALU control unit. Decodes the 6-bit R-type funct into registered control codes for the ALU, shifter,

---
 rtl/multicycle_alu_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/multicycle_alu_ctrl.sv
// multicycle_alu_ctrl: decodes R-type funct into registered datapath control codes and sequences multi-cycle MULTU/DIVU
module multicycle_alu_ctrl #(
  parameter int FUNCT_W = 6,
  parameter int MUL_LAT = 32,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic [FUNCT_W-1:0] alu_op,
  output logic [FUNCT_W-1:0] sht_op,
  output logic [FUNCT_W-1:0] mut_op,
  output logic [FUNCT_W-1:0] mux_op,
  output logic               busy,
  output logic               hilo_we,
  output logic               illegal
);
  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SRL   = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] HILO_WR = '1;
  localparam logic [CNT_W-1:0]   L_MUL   = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0]   L_DIV   = CNT_W'(DIV_LAT);

  if (MUL_LAT < 2 || DIV_LAT < 2 || MUL_LAT > (1 << CNT_W) - 1 || DIV_LAT > (1 << CNT_W) - 1) begin : g_bad_lat
    $error("multicycle_alu_ctrl: latencies must be in [2, 2**CNT_W-1]");
  end

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt, r_lat, w_lat;
  logic [FUNCT_W-1:0] r_ctrl, w_ctrl;
  logic               r_busy, w_busy, r_hilo_we, w_hilo_we, r_illegal, w_illegal;
  logic               w_single, w_multi;

  assign w_single = funct inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL, F_MFHI, F_MFLO};
  assign w_multi  = funct inside {F_MULTU, F_DIVU};

  // state, counter and all outputs are registered; reset drops any in-flight op silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_lat     <= '0;
      r_ctrl    <= '0;
      r_busy    <= 1'b0;
      r_hilo_we <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_lat     <= w_lat;
      r_ctrl    <= w_ctrl;
      r_busy    <= w_busy;
      r_hilo_we <= w_hilo_we;
      r_illegal <= w_illegal;
    end
  end

  // next state and next registered outputs; anything not driven below returns to NOP/idle
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_lat     = r_lat;
    w_ctrl    = '0;
    w_busy    = 1'b0;
    w_hilo_we = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      IDLE: if (op_valid && !flush) begin
        if (w_single) w_ctrl = funct;
        else if (w_multi) begin
          w_ctrl  = funct;
          w_busy  = 1'b1;
          w_cnt   = CNT_W'(1);
          w_lat   = (funct == F_MULTU) ? L_MUL : L_DIV;
          w_state = RUN;
        end else w_illegal = 1'b1;
      end
      RUN: if (flush) w_state = IDLE;
      else begin
        w_busy    = 1'b1;
        w_cnt     = r_cnt + 1'b1;
        w_hilo_we = (r_cnt == r_lat - 1'b1);
        w_ctrl    = w_hilo_we ? HILO_WR : r_ctrl;
        w_state   = w_hilo_we ? WB : RUN;
      end
      default: w_state = IDLE;
    endcase
  end

  assign alu_op  = r_ctrl;
  assign sht_op  = r_ctrl;
  assign mut_op  = r_ctrl;
  assign mux_op  = r_ctrl;
  assign busy    = r_busy;
  assign hilo_we = r_hilo_we;
  assign illegal = r_illegal;
endmodule
